fp_post_normalize: RTL and testbench
====================================

Name: fp_post_normalize

Overview:
- Back end of the FP adder datapath. Counterpart to the exponent-difference/alignment stage.
- Takes the raw sign, exponent and extended-mantissa sum from the adder and normalizes it. Left-shifts iteratively on cancellation, or right-shifts by 1 on carry-out.
- Applies round-to-nearest-even and flags zero, overflow and underflow.
- Valid/ready on both sides; one operation in flight.

Parameters:
EXP_W, 11, exponent width (IEEE double).
FRAC_W, 52, stored fraction width; internal mantissa MW = FRAC_W+4.

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand present.
in_ready  output  1  block can accept.
in_sign  input  1  sum sign.
in_exp  input  EXP_W  biased exponent of larger operand.
in_mant  input  MW  [MW-1]=carry, [MW-2]=hidden, [MW-3:2]=fraction, [1]=guard, [0]=sticky.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts.
out_sign  output  1  result sign.
out_exp  output  EXP_W  result biased exponent.
out_frac  output  FRAC_W  result fraction.
out_zero  output  1  result is zero.
out_ovfl  output  1  overflowed to infinity.
out_unfl  output  1  result denormal.

Behaviour:
- Reset (async, any state): state=IDLE. in_ready=1. All outputs and flags 0, out_valid=0.
- Work registers: sign, exp (EXP_W+1 bits internally), mant (MW), flags.
- IDLE: in_ready=1. Accept on in_valid at a rising edge and latch inputs, then branch:
  - mant==0: out_zero=1, exp=0, frac=0; go to DONE.
  - carry bit set: mant>>1, sticky|=dropped bit, exp+1; go to ROUND.
  - hidden set, or in_exp==0: go to ROUND.
  - otherwise: go to SHIFT.
- SHIFT: one bit per cycle.
  - Hidden set: go to ROUND.
  - exp==1 and hidden clear: exp=0, unfl=1; go to ROUND.
  - Otherwise: mant<<1 (zero fill), exp-1; stay in SHIFT.
  - At most MW-2 iterations.
- ROUND: single cycle.
  - Round up iff guard & (sticky | frac LSB); add 1 at bit 2.
  - Round carry into carry bit: mant>>1, exp+1.
  - Denormal rounding into hidden: exp 0->1, unfl=0.
  - exp >= 2^EXP_W-1 after any increment: exp=all ones, frac=0, ovfl=1.
  - Go to DONE.
- DONE: out_valid=1, outputs stable. in_ready=0. On out_ready at an edge, go to IDLE and drop out_valid.
- Latency from the accept edge to out_valid high:
  - 2 cycles for carry, already-normalized, or zero input (zero: 1 cycle).
  - 3+k cycles with k left shifts.
- No accept in the same cycle as output handoff; one idle cycle between operations.
- out_sign = latched sign, including for zero results (no sign fixing here).
- Reset mid-operation discards the operation; no output is produced.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, FRAC_W, MW.
  - EXP_MAX (all ones), EXP_BIAS=1023.
  - Mantissa bit-index constants: CARRY, HIDDEN, GUARD, STICKY.
  - State enum IDLE/SHIFT/ROUND/DONE.
- One natural sub-module: fp_round_rne, combinational. Takes mant and exp; returns the rounded mant, the adjusted exp, and the overflow flag.

Test Plan:
- Normalized input: exp=1023, mant=hidden only, G=S=0 -> out_exp=1023, frac=0, flags 0; out_valid 2 cycles after accept.
- Carry-out: exp=1023, mant bits 55 and 54 set -> out_exp=1024, frac=2^51; latency 2.
- Cancellation: exp=1000, mant=only bit 50 -> 4 shifts, out_exp=996, frac=0; latency 7.
- Underflow: exp=3, mant=only bit 48 -> 2 shifts to exp 1, then denormal -> out_exp=0, frac=2^48, unfl=1.
- Overflow: exp=2046, carry set -> out_exp=2047, frac=0, ovfl=1.
- Rounding carry: exp=1023, hidden+all fraction ones, G=1 -> out_exp=1024, frac=0.
- Tie-to-even: exp=1023, frac LSB 0, G=1, S=0 -> no increment.
- Zero: mant=0 -> out_zero=1, out_exp=0.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
- Mid-operation reset: assert rst_n low during SHIFT -> immediate IDLE, out_valid=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, mantissa bit positions and FSM encoding for the FP adder back end.
package fp_pkg;
    localparam int unsigned EXP_W  = 11;
    localparam int unsigned FRAC_W = 52;
    localparam int unsigned MW     = FRAC_W + 4;

    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam int unsigned      EXP_BIAS = 1023;

    // Extended mantissa layout: carry | hidden | fraction | guard | sticky
    localparam int unsigned CARRY    = MW - 1;
    localparam int unsigned HIDDEN   = MW - 2;
    localparam int unsigned FRAC_LSB = 2;
    localparam int unsigned GUARD    = 1;
    localparam int unsigned STICKY   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/fp_post_normalize_if.sv
// Operand-in / result-out handshake bundle of the post-normalize stage.
interface fp_post_normalize_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MW-1:0]     in_mant;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [FRAC_W-1:0] out_frac;
    logic              out_zero;
    logic              out_ovfl;
    logic              out_unfl;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac,
               out_zero, out_ovfl, out_unfl
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac,
               out_zero, out_ovfl, out_unfl
    );
endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on the extended mantissa with exponent fix-up.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MW-1:0]  mant,
    input  logic [EXP_W:0] exp,
    output logic [MW-1:0]  mant_rnd,
    output logic [EXP_W:0] exp_rnd,
    output logic           ovfl
);
    logic          round_up;
    logic [MW-1:0] inc;
    logic [MW-1:0] sum;

    always_comb begin
        round_up      = mant[GUARD] & (mant[STICKY] | mant[FRAC_LSB]);
        inc           = '0;
        inc[FRAC_LSB] = round_up;
        sum           = mant + inc;
        mant_rnd      = sum;
        exp_rnd       = exp;
        ovfl          = 1'b0;
        if (sum[CARRY]) begin
            mant_rnd = sum >> 1;
            exp_rnd  = exp + (EXP_W+1)'(1);
        end else if (exp == '0 && sum[HIDDEN]) begin
            // denormal rounded up into the hidden bit becomes the smallest normal
            exp_rnd = (EXP_W+1)'(1);
        end
        if (exp_rnd >= {1'b0, EXP_MAX}) begin
            exp_rnd          = {1'b0, EXP_MAX};
            mant_rnd         = '0;
            mant_rnd[HIDDEN] = 1'b1;
            ovfl             = 1'b1;
        end
    end
endmodule

// File: rtl/fp_post_normalize.sv
// FP adder back end: normalizes the raw sum (1-bit right or iterative left shift), rounds RNE, flags.
module fp_post_normalize
    import fp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    fp_post_normalize_if.slave bus
);
    state_t         state;
    state_t         state_nxt;
    logic           sign_q;
    logic [EXP_W:0] exp_q;
    logic [MW-1:0]  mant_q;
    logic           zero_q;
    logic           ovfl_q;
    logic           unfl_q;

    logic [MW-1:0]  r_mant;
    logic [EXP_W:0] r_exp;
    logic           r_ovfl;

    fp_round_rne u_round (
        .mant     (mant_q),
        .exp      (exp_q),
        .mant_rnd (r_mant),
        .exp_rnd  (r_exp),
        .ovfl     (r_ovfl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_mant == '0)
                        state_nxt = DONE;
                    else if (bus.in_mant[CARRY] || bus.in_mant[HIDDEN] || bus.in_exp == '0)
                        state_nxt = ROUND;
                    else
                        state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q[HIDDEN] || exp_q == (EXP_W+1)'(1))
                    state_nxt = ROUND;
            end
            ROUND:   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
            zero_q <= 1'b0;
            ovfl_q <= 1'b0;
            unfl_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.in_sign;
                        zero_q <= 1'b0;
                        ovfl_q <= 1'b0;
                        unfl_q <= 1'b0;
                        if (bus.in_mant == '0) begin
                            exp_q  <= '0;
                            mant_q <= '0;
                            zero_q <= 1'b1;
                        end else if (bus.in_mant[CARRY]) begin
                            // guard and sticky fold into the new sticky
                            mant_q <= {1'b0, bus.in_mant[MW-1:2], bus.in_mant[GUARD] | bus.in_mant[STICKY]};
                            exp_q  <= {1'b0, bus.in_exp} + (EXP_W+1)'(1);
                        end else begin
                            mant_q <= bus.in_mant;
                            exp_q  <= {1'b0, bus.in_exp};
                        end
                    end
                end
                SHIFT: begin
                    if (!mant_q[HIDDEN]) begin
                        if (exp_q == (EXP_W+1)'(1)) begin
                            exp_q  <= '0;
                            unfl_q <= 1'b1;
                        end else begin
                            mant_q <= mant_q << 1;
                            exp_q  <= exp_q - (EXP_W+1)'(1);
                        end
                    end
                end
                ROUND: begin
                    mant_q <= r_mant;
                    exp_q  <= r_exp;
                    ovfl_q <= r_ovfl;
                    if (r_exp != '0) unfl_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sign = sign_q;
    assign bus.out_exp  = exp_q[EXP_W-1:0];
    assign bus.out_frac = mant_q[MW-3:FRAC_LSB];
    assign bus.out_zero = zero_q;
    assign bus.out_ovfl = ovfl_q;
    assign bus.out_unfl = unfl_q;
endmodule

// File: tb/tb_fp_post_normalize.sv
// Table-driven scoreboard bench for fp_post_normalize, plus backpressure and mid-operation reset sequences.
module tb_fp_post_normalize;
    import fp_pkg::*;

    typedef struct {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MW-1:0]     mant;
        logic [EXP_W-1:0]  e_exp;
        logic [FRAC_W-1:0] e_frac;
        logic              e_zero;
        logic              e_ovfl;
        logic              e_unfl;
        int                lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   applied = 0;
    int   miscompares = 0;
    vec_t sb[$];
    vec_t vecs[14];

    fp_post_normalize_if bus();

    fp_post_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_result(input vec_t e, input string tag);
        chk({tag, " out_valid"}, bus.out_valid, 1);
        chk({tag, " in_ready"},  bus.in_ready, 0);
        chk({tag, " sign"},      bus.out_sign, e.sign);
        chk({tag, " exp"},       bus.out_exp, e.e_exp);
        chk({tag, " frac"},      bus.out_frac, e.e_frac);
        chk({tag, " zero"},      bus.out_zero, e.e_zero);
        chk({tag, " ovfl"},      bus.out_ovfl, e.e_ovfl);
        chk({tag, " unfl"},      bus.out_unfl, e.e_unfl);
    endtask

    // Drive one operation, wait for its result, compare, optionally stall out_ready, then hand off.
    task automatic apply(input vec_t v, input int idx, input int hold);
        int   lat;
        int   waits;
        vec_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, " in_ready before accept"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_sign  = v.sign;
        bus.in_exp   = v.exp;
        bus.in_mant  = v.mant;
        sb.push_back(v);
        applied++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, v.lat);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check_result(e, tag);
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                check_result(e, {tag, " stalled"});
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " out_valid after handoff"}, bus.out_valid, 0);
        chk({tag, " in_ready after handoff"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b0;

        //            sign exp   mant                                   e_exp e_frac             z  o  u  lat
        vecs[0]  = '{1'b0, 11'd1023, 56'h40000000000000,                11'd1023, 52'h0,             0, 0, 0, 2};
        vecs[1]  = '{1'b1, 11'd1023, 56'hC0000000000000,                11'd1024, 52'h8000000000000, 0, 0, 0, 2};
        vecs[2]  = '{1'b0, 11'd1000, 56'h04000000000000,                11'd996,  52'h0,             0, 0, 0, 7};
        vecs[3]  = '{1'b0, 11'd3,    56'h01000000000000,                11'd0,    52'h1000000000000, 0, 0, 1, 5};
        vecs[4]  = '{1'b0, 11'd2046, 56'h80000000000000,                11'd2047, 52'h0,             0, 1, 0, 2};
        vecs[5]  = '{1'b0, 11'd1023, {2'b01, 52'hFFFFFFFFFFFFF, 2'b10}, 11'd1024, 52'h0,             0, 0, 0, 2};
        vecs[6]  = '{1'b0, 11'd1023, {2'b01, 52'h2, 2'b10},             11'd1023, 52'h2,             0, 0, 0, 2};
        vecs[7]  = '{1'b1, 11'd1023, {2'b01, 52'h3, 2'b10},             11'd1023, 52'h4,             0, 0, 0, 2};
        vecs[8]  = '{1'b0, 11'd1023, {2'b01, 52'h2, 2'b11},             11'd1023, 52'h3,             0, 0, 0, 2};
        vecs[9]  = '{1'b1, 11'd500,  56'h0,                             11'd0,    52'h0,             1, 0, 0, 1};
        vecs[10] = '{1'b0, 11'd1023, {2'b11, 52'h1, 2'b01},             11'd1024, 52'h8000000000001, 0, 0, 0, 2};
        vecs[11] = '{1'b0, 11'd1,    {2'b00, 52'hFFFFFFFFFFFFF, 2'b10}, 11'd1,    52'h0,             0, 0, 0, 3};
        vecs[12] = '{1'b0, 11'd0,    {2'b00, 52'h5, 2'b00},             11'd0,    52'h5,             0, 0, 0, 2};
        vecs[13] = '{1'b0, 11'd1000, 56'h20000000000003,                11'd999,  52'h2,             0, 0, 0, 4};

        #23;
        chk("reset in_ready",  bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_exp",   bus.out_exp, 0);
        chk("reset out_frac",  bus.out_frac, 0);
        chk("reset flags",     {bus.out_sign, bus.out_zero, bus.out_ovfl, bus.out_unfl}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) apply(vecs[i], i, 0);

        // Backpressure: result must hold for 10 stalled cycles
        apply(vecs[7], 100, 10);

        // Reset during SHIFT: operation discarded, no result ever appears
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 11'd1000;
        bus.in_mant  = 56'h00000000000400;
        applied++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", bus.out_valid, 0);
        chk("midreset in_ready",  bus.in_ready, 1);
        chk("midreset out_exp",   bus.out_exp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (60) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) seen++;
            end
            chk("midreset no output", seen, 0);
        end

        apply(vecs[1], 200, 0);
        chk("scoreboard drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
